// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding and default word width.
package uart_pkg;

  localparam int DEFAULT_NUM_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder: picks the first requester at or after last+1,
// wrapping back to zero past NUM_REQ-1.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Wrap is an explicit compare so non-power-of-two NUM_REQ never visits unused indices.
  always_comb begin
    w_found = 1'b0;
    o_idx   = '0;
    w_cand  = (i_last == IDX_MAX) ? '0 : i_last + IDX_W'(1);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        o_idx   = w_cand;
      end
      w_cand = (w_cand == IDX_MAX) ? '0 : w_cand + IDX_W'(1);
    end
  end

  assign o_any    = w_found;
  assign o_onehot = w_found ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte FIFOs,
// holding each grant for up to BURST_LEN words so messages stay contiguous.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_BITS  = DEFAULT_NUM_BITS,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ*NUM_BITS-1:0] i_req_data,
  output logic [NUM_REQ-1:0]          o_req_pop,
  output logic [NUM_BITS-1:0]         o_tx_data,
  output logic                        o_tx_start,
  input  logic                        i_tx_busy,
  input  logic                        i_tx_done,
  output logic [NUM_REQ-1:0]          o_grant,
  output logic                        o_grant_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic                 r_grant_valid, w_grant_valid_nxt;
  logic [IDX_W-1:0]     r_last, w_last_nxt;
  logic [CNT_W-1:0]     r_count, w_count_nxt;
  logic [NUM_BITS-1:0]  r_tx_data, w_tx_data_nxt;
  logic                 r_tx_start, w_tx_start_nxt;
  logic [NUM_REQ-1:0]   r_req_pop, w_req_pop_nxt;

  logic [NUM_REQ-1:0]   w_pick_onehot;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_any;
  logic                 w_g_valid;
  logic [NUM_BITS-1:0]  w_g_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req    (i_req_valid),
    .i_last   (r_last),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // While a grant is held, r_last is the granted index.
  assign w_g_valid = i_req_valid[r_last];
  assign w_g_data  = i_req_data[int'(r_last) * NUM_BITS +: NUM_BITS];

  always_comb begin
    w_state_nxt       = r_state;
    w_grant_nxt       = r_grant;
    w_grant_valid_nxt = r_grant_valid;
    w_last_nxt        = r_last;
    w_count_nxt       = r_count;
    w_tx_data_nxt     = r_tx_data;
    w_tx_start_nxt    = 1'b0;
    w_req_pop_nxt     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt       = w_pick_onehot;
          w_grant_valid_nxt = 1'b1;
          w_last_nxt        = w_pick_idx;
          w_count_nxt       = '0;
          w_state_nxt       = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!w_g_valid) begin
          w_grant_nxt       = '0;
          w_grant_valid_nxt = 1'b0;
          w_state_nxt       = ST_IDLE;
        end else if (!i_tx_busy) begin
          w_tx_data_nxt  = w_g_data;
          w_tx_start_nxt = 1'b1;
          w_req_pop_nxt  = r_grant;
          w_count_nxt    = r_count + CNT_W'(1);
          w_state_nxt    = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          if ((r_count == CNT_MAX) || !w_g_valid) begin
            w_grant_nxt       = '0;
            w_grant_valid_nxt = 1'b0;
            w_state_nxt       = ST_IDLE;
          end else begin
            w_state_nxt = ST_SEND;
          end
        end
      end
      default: begin
        w_grant_nxt       = '0;
        w_grant_valid_nxt = 1'b0;
        w_state_nxt       = ST_IDLE;
      end
    endcase
  end

  // Last pointer resets to NUM_REQ-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_last        <= LAST_RST;
      r_count       <= '0;
      r_tx_data     <= '0;
      r_tx_start    <= 1'b0;
      r_req_pop     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_last        <= w_last_nxt;
      r_count       <= w_count_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_req_pop     <= w_req_pop_nxt;
    end
  end

  assign o_req_pop     = r_req_pop;
  assign o_tx_data     = r_tx_data;
  assign o_tx_start    = r_tx_start;
  assign o_grant       = r_grant;
  assign o_grant_valid = r_grant_valid;

endmodule
